// File: rtl/nibble_alu_seq.sv
// Multi-cycle ADD/ADC/SUB/SBB sequencer: one nibble per clock through a single
// shared 4-bit carry-lookahead adder, with carry rippled through a register.

module nibble_cla4 (
  input  logic       i_cin,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Flattened lookahead terms: every carry depends only on g/p and i_cin.
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
endmodule

module nibble_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_next;
  logic             r_cin;
  logic             w_cin_sel;
  logic             w_last;
  logic [3:0]       w_sum;
  logic             w_cout;

  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_flag_c;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_v;

  nibble_cla4 u_cla (
    .i_cin  (r_cin),
    .i_a    (r_opa[{r_idx, 2'b00} +: 4]),
    .i_b    (r_opb[{r_idx, 2'b00} +: 4]),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // op[1] selects subtraction, op[0] selects chaining through the carry flag.
  assign w_cin_sel = op[0] ? r_flag_c : op[1];
  assign w_last    = (r_idx == LAST_IDX);

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    w_work_next = r_work;
    w_work_next[{r_idx, 2'b00} +: 4] = w_sum;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: operand and working registers are reset too, so an aborted operation
  // leaves no residue visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_work   <= '0;
      r_cin    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_v <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa <= a;
            r_opb <= op[1] ? ~b : b;
            r_cin <= w_cin_sel;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          r_work <= w_work_next;
          r_cin  <= w_cout;
          if (w_last) begin
            r_result <= w_work_next;
            r_done   <= 1'b1;
            r_flag_c <= w_cout;
            r_flag_z <= (w_work_next == '0);
            r_flag_n <= w_sum[3];
            // Overflow: like-signed operands producing an opposite-signed sum.
            r_flag_v <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_sum[3] != r_opa[WIDTH-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign result = r_result;
  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
  assign flag_v = r_flag_v;
endmodule

// File: tb/tb_nibble_alu_seq.sv
// Directed bench for nibble_alu_seq (WIDTH=8): handshake timing, flags, carry
// chaining, ignored start while busy, and asynchronous reset mid-operation.

module tb_nibble_alu_seq;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int busy_cnt;

  nibble_alu_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_v (flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] r,
                           input logic c, input logic z, input logic n, input logic v);
    check({tag, "_result"}, {24'h0, result}, {24'h0, r});
    check({tag, "_flags"}, {28'h0, flag_c, flag_z, flag_n, flag_v}, {28'h0, c, z, n, v});
  endtask

  // Called at a negedge after the accept edge; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag);
    while (!done && lat < 12) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, {31'h0, done}, 32'h1);
    check({tag, "_busy_in_done"}, {31'h0, busy}, 32'h0);
  endtask

  // Called at a negedge; drives a request that is accepted at the next posedge.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        input string tag);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    wait_done(tag);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs", {20'h0, busy, done, result, flag_c, flag_z, flag_n, flag_v}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 0x3A + 0x4C = 0x86: positive + positive -> negative overflow.
    run_op(OP_ADD, 8'h3A, 8'h4C, "add_3a_4c");
    check("add_latency", lat, 3);
    check("add_busy_cycles", busy_cnt, 2);
    check_res("add_3a_4c", 8'h86, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("result_held", {24'h0, result}, 32'h86);

    run_op(OP_SUB, 8'h50, 8'h50, "sub_equal");
    check_res("sub_equal", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    run_op(OP_SUB, 8'h10, 8'h20, "sub_borrow");
    check_res("sub_borrow", 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Carry chain: the ADC is requested in the done cycle of the ADD.
    run_op(OP_ADD, 8'hFF, 8'h01, "add_wrap");
    check_res("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op(OP_ADC, 8'h00, 8'h00, "adc_chain");
    check("adc_b2b_latency", lat, 3);
    check_res("adc_chain", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

    // SBB with C=0 subtracts an extra one; then with C=1 no extra borrow.
    run_op(OP_SBB, 8'h05, 8'h01, "sbb_c0");
    check_res("sbb_c0", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(OP_SBB, 8'h80, 8'h01, "sbb_c1");
    check_res("sbb_c1", 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // start pulsed while busy with other operands must be ignored.
    start = 1'b1; op = OP_ADD; a = 8'h12; b = 8'h34;
    @(negedge clk);
    check("busy_after_accept", {31'h0, busy}, 32'h1);
    op = OP_SUB; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    busy_cnt = 1;
    wait_done("ignore_start");
    check("ignore_latency", lat, 3);
    check_res("ignore_start", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("no_queued_op", {31'h0, busy}, 32'h0);
    check("ignore_result_held", {24'h0, result}, 32'h46);

    // Asynchronous reset in the middle of an operation.
    start = 1'b1; op = OP_ADD; a = 8'h3A; b = 8'h4C;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {20'h0, busy, done, result, flag_c, flag_z, flag_n, flag_v}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_done", {30'h0, busy, done}, 32'h0);
    end
    check("rst_result_zero", {24'h0, result}, 32'h0);

    // ADC after reset uses the cleared carry flag.
    run_op(OP_ADC, 8'h01, 8'h02, "post_reset_adc");
    check("post_reset_latency", lat, 3);
    check_res("post_reset_adc", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/nibble_alu_seq.md
# nibble_alu_seq

Multi-cycle add/subtract sequencer that computes WIDTH-bit ADD/ADC/SUB/SBB one nibble per clock on a single shared 4-bit carry-lookahead adder. It sits between the CPU control unit and the accumulator datapath. It accepts an operation with a start/busy/done handshake, ripples the carry between nibbles through a register, and maintains the C, Z, N and V status flags.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBB
- a  in  WIDTH  operand A, captured on accept
- b  in  WIDTH  operand B, captured on accept
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse: result and flags updated
- result  out  WIDTH  last completed result, held until next done
- flag_c  out  1  carry; 1 = no borrow for SUB/SBB
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]
- flag_v  out  1  signed overflow

## Operation
- The block contains exactly one 4-bit adder instance (c_in, A[3:0], B[3:0] → sum[3:0], c_out). No other adder is permitted.
- States: IDLE and RUN. A nibble index idx counts 0..NIB-1.
- IDLE:
  - start=1 → capture a into opa and b into opb.
  - For SUB/SBB, capture ~b instead of b.
  - Capture carry-in cin:
    - ADD: 0
    - ADC: flag_c
    - SUB: 1
    - SBB: flag_c
  - Set idx=0 and go to RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - Adder inputs are nibble idx of opa and opb, with c_in = cin.
  - Write sum into nibble idx of the working register and set cin ← c_out.
  - If idx = NIB-1: go to IDLE, copy the working register to result, update the flags, and pulse done. Otherwise idx ← idx+1.
- Flags are updated only at completion:
  - flag_c = c_out of the last nibble
  - flag_z = (new result == 0)
  - flag_n = new result MSB
  - flag_v = (opa MSB == opb MSB) && (result MSB != opa MSB), where opb is the inverted operand for SUB/SBB
- start while busy is ignored. It is not queued and does not disturb operands.
- op and operand changes after accept have no effect.
- Reset (any time, including mid-RUN) asynchronously forces:
  - state IDLE, idx 0
  - busy 0, done 0
  - result 0
  - all flags 0
  - working registers 0
- An operation in flight at reset is discarded and no done is produced.

## Timing
- All outputs are registered.
- Accept edge E0: start=1 while in IDLE.
- busy is high from after E0 until after E(NIB). For the default WIDTH=8, busy is high for 2 cycles.
- Latency:
  - result, flags and done change together after edge E(NIB), which is E2 for WIDTH=8.
  - done is high for exactly one cycle.
- Throughput:
  - The state is IDLE during the done cycle, so start may be accepted in that same cycle.
  - One operation completes every NIB+1 cycles back-to-back.
- Back-to-back ADC/SBB: flag_c written at E(NIB) is the value captured at the next accept edge, so multi-word chains need no bubble.
- result and flags hold between completions. busy and done are never high in the same cycle.

## Test plan
- Reset, then ADD a=0x3A b=0x4C:
  - done after exactly 3 cycles from accept (WIDTH=8)
  - result=0x86, C=0, Z=0, N=1, V=1
  - busy high for exactly 2 cycles
- SUB a=0x50 b=0x50 → result=0x00, C=1, Z=1, N=0, V=0.
- SUB a=0x10 b=0x20 → result=0xF0, C=0, N=1, V=0.
- Carry chain: ADD 0xFF+0x01, then start=1 held in the done cycle with ADC 0x00+0x00:
  - first op: result=0x00, C=1, Z=1
  - second op accepted immediately: result=0x01, C=0, Z=0
- SBB with flag_c=0: a=0x05 b=0x01 → result=0x03, C=1. Then SBB with C=1: a=0x80 b=0x01 → result=0x7F, V=1.
- Robustness:
  - Pulse start again on the cycle after accept with different a/b/op. It must be ignored and the first result must be unchanged.
  - Drop rst_n during RUN. All outputs must be 0 immediately (asynchronous), no done pulse may appear, and the next op after release must run normally.
